// File: rtl/data_2048x2_port_ctrl.sv
// Initiator-side controller for the 2048x2 dual-port array macro: zero-fills the array after reset,
// then serves one read/write request per cycle with in-order, credit-limited read responses.
//
// state   | meaning
// --------+-----------------------------------------------------
// S_WAKE  | one idle cycle after reset, all macro enables low
// S_CLEAR | sweep counter writes 0 to every entry, requests blocked
// S_RUN   | init done, client requests served until next reset
module data_2048x2_port_ctrl #(
    parameter int DEPTH      = 2048,
    parameter int AW         = 11,
    parameter int DW         = 2,
    parameter int RESP_DEPTH = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          init_done,
    output logic [AW-1:0] R0_addr,
    output logic          R0_en,
    output logic          R0_clk,
    output logic [AW-1:0] W0_addr,
    output logic          W0_en,
    output logic          W0_clk,
    output logic [DW-1:0] W0_data,
    input  logic [DW-1:0] R0_data
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    typedef enum logic [1:0] {
        S_WAKE,
        S_CLEAR,
        S_RUN
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_sweep;
    logic [DW-1:0] r_fifo [RESP_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_inflight;

    logic [CW:0]   w_used;
    logic          w_run;
    logic          w_clear;
    logic          w_acc;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_run   = (r_state == S_RUN);
    assign w_clear = (r_state == S_CLEAR);

    // A read in flight already owns a FIFO slot, so it counts against the credit.
    assign w_used    = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign req_ready = w_run && (w_used < (CW+1)'(RESP_DEPTH));

    assign w_acc    = req_valid & req_ready;
    assign w_wr_acc = w_acc & req_write;
    assign w_rd_acc = w_acc & ~req_write;

    assign w_push     = r_inflight;
    assign resp_valid = (r_count != '0);
    assign w_pop      = resp_valid & resp_ready;
    assign resp_data  = resp_valid ? r_fifo[r_rd_ptr] : '0;
    assign init_done  = w_run;

    assign R0_en   = w_rd_acc;
    assign R0_addr = w_rd_acc ? req_addr : '0;
    assign W0_en   = w_clear | w_wr_acc;
    assign W0_addr = w_clear ? r_sweep : (w_wr_acc ? req_addr : '0);
    assign W0_data = w_wr_acc ? req_data : '0;
    assign R0_clk  = clock;
    assign W0_clk  = clock;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_WAKE;
            r_sweep <= '0;
        end else begin
            case (r_state)
                S_WAKE: r_state <= S_CLEAR;
                S_CLEAR: begin
                    r_sweep <= r_sweep + AW'(1);
                    if (r_sweep == AW'(DEPTH - 1)) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN:   r_state <= S_RUN;
                default: r_state <= S_WAKE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_inflight <= w_rd_acc;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= R0_data;
                r_wr_ptr         <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
